pxie_rx_data: RTL and testbench
===============================

# pxie_rx_data

Host-to-card (H2C) receive datapath for the PXIe link. The block accepts a 64-bit AXI-Stream transfer from the PXIe DMA H2C channel and splits each beat into two 32-bit words. It writes those words into system RAM starting at a programmed address, for a programmed word count. It sits between the DMA H2C stream port and the system RAM write port, all in the single `h2c_clk` domain, and reports completion and length-mismatch status to the control logic.

## Interface
- No parameters; widths fixed: 64-bit stream, 32-bit RAM word, 16-bit address and length.
- `h2c_clk` in 1: the only clock; every flop in the block uses it.
- `rst` in 1: reset, asynchronous, active-high.
- `h2c_addr` in 16: RAM start word address, sampled on `h2c_en`.
- `h2c_len` in 16: number of 32-bit words to write, sampled on `h2c_en`.
- `h2c_en` in 1: single-cycle start pulse; acted on only in IDLE.
- `h2c_tdata` in 64: stream data; `[31:0]` is the first word, `[63:32]` the second.
- `h2c_tvalid` in 1: stream valid.
- `h2c_tlast` in 1: last beat of the transfer.
- `h2c_tkeep` in 8: byte enables; each 32-bit half is valid only when its 4 keep bits are `4'hF`.
- `h2c_tready` out 1: stream ready.
- `sysRAM_we` out 1: RAM write strobe (registered).
- `sysRAM_addr` out 16: RAM word address (registered).
- `sysRAM_wdata` out 32: RAM write data (registered).
- `h2c_busy` out 1: high in every state except IDLE.
- `h2c_done` out 1: one-cycle pulse when the transfer ends.
- `h2c_err_short` out 1: `tlast` arrived before `h2c_len` words were written. Sticky until the next accepted `h2c_en`.
- `h2c_err_long` out 1: beats arrived after `h2c_len` words were written. Sticky until the next accepted `h2c_en`.

## Operation
- States: IDLE, RECV, WR_HI, DRAIN, DONE.
- Registers:
  - `cur_addr`, 16 bits; increments modulo 2^16, so `16'hFFFF` wraps to `16'h0000`.
  - `word_cnt`, 16 bits.
  - `len_r`, 16 bits.
  - Beat holding register: 32-bit high word, high keep nibble, last flag.
- IDLE:
  - `h2c_tready` = 0.
  - On `h2c_en`: load `cur_addr` ← `h2c_addr`, `len_r` ← `h2c_len`, `word_cnt` ← 0, and clear both error flags.
  - If `h2c_len` == 0, go to DONE; otherwise go to RECV.
- RECV:
  - `h2c_tready` = 1.
  - On handshake (`tvalid & tready`), write the low word if `tkeep[3:0]` == F and `word_cnt` < `len_r`. A write loads `sysRAM_we` = 1, `sysRAM_addr` = `cur_addr`, `sysRAM_wdata` = `tdata[31:0]`, then increments `cur_addr` and `word_cnt`.
  - Also latch the high half, its keep nibble and `tlast`, then go to WR_HI.
- WR_HI:
  - `h2c_tready` = 0.
  - Write the held high word under the same rule: its nibble must be F and the (updated) `word_cnt` must be < `len_r`.
  - Next state, evaluated with the count after this cycle's write, first match wins:
    - last flag set and count < `len_r` → set `err_short`, go to DONE;
    - last flag set → DONE;
    - count == `len_r` → DRAIN;
    - otherwise → RECV.
- DRAIN:
  - `h2c_tready` = 1; no RAM writes.
  - Any handshake sets `err_long`.
  - Handshake with `tlast` → DONE.
- DONE: `h2c_done` = 1 for one cycle, then IDLE.
- `sysRAM_we` is 0 in every cycle that has no write load.
- Dropped words (keep nibble not F, or count already reached) advance neither the address nor the count.
- `h2c_en` outside IDLE is ignored, with no effect on the transfer or the flags.

## Timing
- Reset values (asynchronous, immediate on `rst` rising):
  - state = IDLE;
  - `h2c_tready`, `sysRAM_we`, `h2c_busy`, `h2c_done`, both error flags = 0;
  - `sysRAM_addr` = 0, `sysRAM_wdata` = 0.
- Reset mid-transfer aborts immediately. RAM words already written stay written. There is no `done` pulse.
- `h2c_en` at edge N → `h2c_tready` = 1 in cycle N+1.
- Handshake at edge K → low-word write visible in cycle K+1, high-word write in cycle K+2. `h2c_tready` returns in cycle K+2 when going back to RECV.
- Throughput is 1 beat per 2 cycles, i.e. one 32-bit RAM write per cycle sustained.
- Final beat handshake at K → `h2c_done` high in cycle K+2 for a normal finish, later if DRAIN is entered.
- `h2c_len` == 0: `h2c_done` one cycle after the `h2c_en` edge; `h2c_tready` stays 0 throughout.
- `tvalid` low in RECV is an idle wait with no timeout. The holding register is never overwritten before WR_HI consumes it.

## Test plan
- Normal: `addr`=0x0100, `len`=4, two beats (0x22221111_11110000, then 0x44443333_33332222 with `tlast`), `tkeep`=FF. Required:
  - writes 0x0100←0x11110000, 0x0101←0x22221111, 0x0102←0x33332222, 0x0103←0x44443333;
  - `done` once; no errors.
- Odd length: `len`=3, two beats with `tlast` on the second. Required: 3 writes; the fourth word is dropped; no errors; `done`.
- Short: `len`=6, `tlast` on beat 2. Required: 4 writes; `err_short`=1; `done`; `err_short` clears on the next `h2c_en`.
- Long: `len`=2, three beats with `tlast` on beat 3. Required: 2 writes; beats 2–3 accepted with no writes; `err_long`=1; `done` after beat 3.
- Keep and wrap:
  - `addr`=0xFFFF, `len`=2, one beat with `tkeep`=FF and `tlast`. Required: writes 0xFFFF, then 0x0000.
  - Separately, `tkeep`=0x0F with `tlast`, `len`=2. Required: one write and `err_short`.
- Backpressure/reset:
  - `tvalid` toggled randomly. Required: data order preserved and `h2c_tready` never high in WR_HI.
  - `rst` pulsed mid-transfer. Required: all outputs 0 immediately, and the next `h2c_en` works normally.

Source files
------------

// File: rtl/pxie_rx_data_if.sv
// H2C AXI-Stream bundle: the DMA side is the master, pxie_rx_data is the slave.
// Pure wiring with no logic; tready is the only slave-driven signal.
interface pxie_rx_data_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pxie_rx_data.sv
// H2C stream to system RAM: each 64-bit beat becomes two 32-bit writes (low word, then high word).
// Low write lands 1 cycle after the handshake and high write 2 cycles after; tready drops while the high half is written.
module pxie_rx_data (
  input  logic                 h2c_clk,
  input  logic                 rst,
  input  logic [15:0]          h2c_addr,
  input  logic [15:0]          h2c_len,
  input  logic                 h2c_en,
  pxie_rx_data_if.slave        h2c,
  output logic                 sysRAM_we,
  output logic [15:0]          sysRAM_addr,
  output logic [31:0]          sysRAM_wdata,
  output logic                 h2c_busy,
  output logic                 h2c_done,
  output logic                 h2c_err_short,
  output logic                 h2c_err_long
);

  typedef enum logic [2:0] {IDLE, RECV, WR_HI, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } hold_t;

  state_t      state, nxt_state;
  hold_t       hold;
  logic [15:0] cur_addr, word_cnt, len_r, cnt_after;
  logic        start, take_beat, lo_wr, hi_wr, set_short, set_long;

  always_ff @(posedge h2c_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state  = state;
    h2c.tready = 1'b0;
    start      = 1'b0;
    take_beat  = 1'b0;
    lo_wr      = 1'b0;
    hi_wr      = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    cnt_after  = word_cnt;
    case (state)
      IDLE: begin
        if (h2c_en) begin
          start     = 1'b1;
          nxt_state = (h2c_len == 16'd0) ? DONE : RECV;
        end
      end
      RECV: begin
        h2c.tready = 1'b1;
        if (h2c.tvalid) begin
          take_beat = 1'b1;
          lo_wr     = (h2c.tkeep[3:0] == 4'hF) && (word_cnt < len_r);
          nxt_state = WR_HI;
        end
      end
      WR_HI: begin
        hi_wr     = (hold.keep == 4'hF) && (word_cnt < len_r);
        // Exit decision uses the count including this cycle's high-word write
        cnt_after = word_cnt + {15'd0, hi_wr};
        if (hold.last && (cnt_after < len_r)) begin
          set_short = 1'b1;
          nxt_state = DONE;
        end else if (hold.last) begin
          nxt_state = DONE;
        end else if (cnt_after == len_r) begin
          nxt_state = DRAIN;
        end else begin
          nxt_state = RECV;
        end
      end
      DRAIN: begin
        h2c.tready = 1'b1;
        if (h2c.tvalid) begin
          set_long = 1'b1;
          if (h2c.tlast) nxt_state = DONE;
        end
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  assign h2c_busy = (state != IDLE);
  assign h2c_done = (state == DONE);

  always_ff @(posedge h2c_clk or posedge rst) begin
    if (rst) begin
      sysRAM_we     <= 1'b0;
      sysRAM_addr   <= 16'd0;
      sysRAM_wdata  <= 32'd0;
      h2c_err_short <= 1'b0;
      h2c_err_long  <= 1'b0;
      cur_addr      <= 16'd0;
      word_cnt      <= 16'd0;
      len_r         <= 16'd0;
      hold          <= '0;
    end else begin
      sysRAM_we <= 1'b0;
      if (start) begin
        cur_addr      <= h2c_addr;
        len_r         <= h2c_len;
        word_cnt      <= 16'd0;
        h2c_err_short <= 1'b0;
        h2c_err_long  <= 1'b0;
      end
      if (take_beat) hold <= {h2c.tdata[63:32], h2c.tkeep[7:4], h2c.tlast};
      // lo_wr and hi_wr live in different states, so at most one write per cycle
      if (lo_wr || hi_wr) begin
        sysRAM_we    <= 1'b1;
        sysRAM_addr  <= cur_addr;
        sysRAM_wdata <= lo_wr ? h2c.tdata[31:0] : hold.dat;
        cur_addr     <= cur_addr + 16'd1;
        word_cnt     <= word_cnt + 16'd1;
      end
      if (set_short) h2c_err_short <= 1'b1;
      if (set_long)  h2c_err_long  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pxie_rx_data.sv
// Directed bench for pxie_rx_data: logs RAM writes at negedge and checks them against hand-computed tables.
module tb_pxie_rx_data;
  logic        h2c_clk = 1'b0;
  logic        rst;
  logic [15:0] h2c_addr, h2c_len;
  logic        h2c_en;
  logic        sysRAM_we;
  logic [15:0] sysRAM_addr;
  logic [31:0] sysRAM_wdata;
  logic        h2c_busy, h2c_done, h2c_err_short, h2c_err_long;

  pxie_rx_data_if h2c ();

  pxie_rx_data dut (
    .h2c_clk       (h2c_clk),
    .rst           (rst),
    .h2c_addr      (h2c_addr),
    .h2c_len       (h2c_len),
    .h2c_en        (h2c_en),
    .h2c           (h2c.slave),
    .sysRAM_we     (sysRAM_we),
    .sysRAM_addr   (sysRAM_addr),
    .sysRAM_wdata  (sysRAM_wdata),
    .h2c_busy      (h2c_busy),
    .h2c_done      (h2c_done),
    .h2c_err_short (h2c_err_short),
    .h2c_err_long  (h2c_err_long)
  );

  always #5 h2c_clk = ~h2c_clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] wr_a[$];
  logic [31:0] wr_d[$];
  int          done_cnt = 0;
  int          viol = 0;
  bit          chk_ready = 0;
  bit          hs_prev = 0;

  always @(negedge h2c_clk) begin
    if (!rst) begin
      if (sysRAM_we) begin
        wr_a.push_back(sysRAM_addr);
        wr_d.push_back(sysRAM_wdata);
      end
      if (h2c_done) done_cnt++;
      if (chk_ready && hs_prev && h2c.tready) viol++;
    end
    hs_prev = h2c.tvalid && h2c.tready && !rst;
  end

  task automatic clear_log;
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] l);
    h2c_addr = a;
    h2c_len  = l;
    h2c_en   = 1'b1;
    @(posedge h2c_clk); #1;
    h2c_en   = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit got = 0;
    int n = 0;
    h2c.tdata  = d;
    h2c.tkeep  = k;
    h2c.tlast  = l;
    h2c.tvalid = 1'b1;
    while (!got && n < 50) begin
      @(negedge h2c_clk);
      got = h2c.tready;
      @(posedge h2c_clk); #1;
      n++;
    end
    h2c.tvalid = 1'b0;
    h2c.tlast  = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL beat_timeout: tready=%0b after %0d cycles, required 1", h2c.tready, n);
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (h2c_busy && n < 100) begin
      @(posedge h2c_clk); #1;
      n++;
    end
    if (h2c_busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy=%0b, required 0", h2c_busy);
    end
    @(posedge h2c_clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    h2c_en = 1'b0; h2c_addr = '0; h2c_len = '0;
    h2c.tvalid = 1'b0; h2c.tdata = '0; h2c.tkeep = '0; h2c.tlast = 1'b0;
    #2;
    tests++;
    if ({h2c.tready, sysRAM_we, h2c_busy, h2c_done, h2c_err_short, h2c_err_long} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {h2c.tready, sysRAM_we, h2c_busy, h2c_done, h2c_err_short, h2c_err_long});
    end
    tests++;
    if ({sysRAM_addr, sysRAM_wdata} !== 48'd0) begin
      fails++;
      $display("FAIL reset_bus: addr=%h wdata=%h, required 0", sysRAM_addr, sysRAM_wdata);
    end
    @(posedge h2c_clk); #1;
    rst = 1'b0;
    @(posedge h2c_clk); #1;
  endtask

  task automatic test_normal;
    logic [15:0] ea[4] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    logic [31:0] ed[4] = '{32'h11110000, 32'h22221111, 32'h33332222, 32'h44443333};
    clear_log();
    start(16'h0100, 16'd4);
    tests++;
    if (h2c.tready !== 1'b1) begin
      fails++; $display("FAIL normal_tready_after_en: got %b, required 1", h2c.tready);
    end
    send_beat(64'h22221111_11110000, 8'hFF, 1'b0);
    send_beat(64'h44443333_33332222, 8'hFF, 1'b1);
    tests++;
    if ({sysRAM_we, sysRAM_addr, h2c_done} !== {1'b1, 16'h0102, 1'b0}) begin
      fails++;
      $display("FAIL normal_lo_latency: we=%b addr=%h done=%b, required 1 0102 0", sysRAM_we, sysRAM_addr, h2c_done);
    end
    @(posedge h2c_clk); #1;
    tests++;
    if ({sysRAM_we, sysRAM_addr, h2c_done} !== {1'b1, 16'h0103, 1'b1}) begin
      fails++;
      $display("FAIL normal_hi_done_latency: we=%b addr=%h done=%b, required 1 0103 1", sysRAM_we, sysRAM_addr, h2c_done);
    end
    wait_idle();
    tests++;
    if (wr_a.size() !== 4) begin
      fails++; $display("FAIL normal_count: got %0d writes, required 4", wr_a.size());
    end
    for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
      tests++;
      if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) begin
        fails++;
        $display("FAIL normal_write%0d: got %h<-%h, required %h<-%h", i, wr_a[i], wr_d[i], ea[i], ed[i]);
      end
    end
    tests++;
    if ({done_cnt, h2c_err_short, h2c_err_long} !== {32'd1, 2'b00}) begin
      fails++;
      $display("FAIL normal_status: done_cnt=%0d short=%b long=%b, required 1 0 0", done_cnt, h2c_err_short, h2c_err_long);
    end
  endtask

  task automatic test_odd;
    logic [31:0] ed[3] = '{32'hA0000000, 32'hA0000001, 32'hA0000002};
    clear_log();
    start(16'h0200, 16'd3);
    send_beat(64'hA0000001_A0000000, 8'hFF, 1'b0);
    send_beat(64'hA0000003_A0000002, 8'hFF, 1'b1);
    wait_idle();
    tests++;
    if (wr_a.size() !== 3) begin
      fails++; $display("FAIL odd_count: got %0d writes, required 3", wr_a.size());
    end
    for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
      tests++;
      if (wr_a[i] !== 16'h0200 + 16'(i) || wr_d[i] !== ed[i]) begin
        fails++;
        $display("FAIL odd_write%0d: got %h<-%h, required %h<-%h", i, wr_a[i], wr_d[i], 16'h0200 + 16'(i), ed[i]);
      end
    end
    tests++;
    if ({done_cnt, h2c_err_short, h2c_err_long} !== {32'd1, 2'b00}) begin
      fails++;
      $display("FAIL odd_status: done_cnt=%0d short=%b long=%b, required 1 0 0", done_cnt, h2c_err_short, h2c_err_long);
    end
  endtask

  task automatic test_short;
    clear_log();
    start(16'h0300, 16'd6);
    send_beat(64'hC0000001_C0000000, 8'hFF, 1'b0);
    send_beat(64'hC0000003_C0000002, 8'hFF, 1'b1);
    wait_idle();
    tests++;
    if (wr_a.size() !== 4) begin
      fails++; $display("FAIL short_count: got %0d writes, required 4", wr_a.size());
    end
    tests++;
    if ({done_cnt, h2c_err_short, h2c_err_long} !== {32'd1, 2'b10}) begin
      fails++;
      $display("FAIL short_status: done_cnt=%0d short=%b long=%b, required 1 1 0", done_cnt, h2c_err_short, h2c_err_long);
    end
    clear_log();
    start(16'h0400, 16'd0);
    tests++;
    if ({h2c_done, h2c_err_short, h2c.tready} !== 3'b100) begin
      fails++;
      $display("FAIL zero_len_done_clear: done=%b short=%b tready=%b, required 1 0 0", h2c_done, h2c_err_short, h2c.tready);
    end
    @(posedge h2c_clk); #1;
    tests++;
    if ({h2c_done, h2c_busy} !== 2'b00) begin
      fails++; $display("FAIL zero_len_idle: done=%b busy=%b, required 0 0", h2c_done, h2c_busy);
    end
  endtask

  task automatic test_long;
    clear_log();
    start(16'h0500, 16'd2);
    send_beat(64'hD0000001_D0000000, 8'hFF, 1'b0);
    send_beat(64'hD0000003_D0000002, 8'hFF, 1'b0);
    tests++;
    if ({h2c_err_long, h2c_done} !== 2'b10) begin
      fails++; $display("FAIL long_mid: err_long=%b done=%b, required 1 0", h2c_err_long, h2c_done);
    end
    send_beat(64'hD0000005_D0000004, 8'hFF, 1'b1);
    tests++;
    if (h2c_done !== 1'b1) begin
      fails++; $display("FAIL long_done_after_last: done=%b, required 1", h2c_done);
    end
    wait_idle();
    tests++;
    if (wr_a.size() !== 2) begin
      fails++; $display("FAIL long_count: got %0d writes, required 2", wr_a.size());
    end
    tests++;
    if ({done_cnt, h2c_err_short, h2c_err_long} !== {32'd1, 2'b01}) begin
      fails++;
      $display("FAIL long_status: done_cnt=%0d short=%b long=%b, required 1 0 1", done_cnt, h2c_err_short, h2c_err_long);
    end
  endtask

  task automatic test_keep_wrap;
    clear_log();
    start(16'hFFFF, 16'd2);
    send_beat(64'hE0000001_E0000000, 8'hFF, 1'b1);
    wait_idle();
    tests++;
    if (wr_a.size() !== 2) begin
      fails++; $display("FAIL wrap_count: got %0d writes, required 2", wr_a.size());
    end else begin
      tests++;
      if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {16'hFFFF, 32'hE0000000, 16'h0000, 32'hE0000001}) begin
        fails++;
        $display("FAIL wrap_writes: got %h<-%h %h<-%h, required FFFF<-E0000000 0000<-E0000001",
                 wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
    end
    tests++;
    if ({h2c_err_short, h2c_err_long} !== 2'b00) begin
      fails++; $display("FAIL wrap_errs: short=%b long=%b, required 0 0", h2c_err_short, h2c_err_long);
    end
    clear_log();
    start(16'h0600, 16'd2);
    send_beat(64'hF0000001_F0000000, 8'h0F, 1'b1);
    wait_idle();
    tests++;
    if (wr_a.size() !== 1) begin
      fails++; $display("FAIL keep_count: got %0d writes, required 1", wr_a.size());
    end else begin
      tests++;
      if ({wr_a[0], wr_d[0]} !== {16'h0600, 32'hF0000000}) begin
        fails++; $display("FAIL keep_write: got %h<-%h, required 0600<-F0000000", wr_a[0], wr_d[0]);
      end
    end
    tests++;
    if ({done_cnt, h2c_err_short} !== {32'd1, 1'b1}) begin
      fails++; $display("FAIL keep_status: done_cnt=%0d short=%b, required 1 1", done_cnt, h2c_err_short);
    end
  endtask

  task automatic test_backpressure;
    clear_log();
    viol = 0;
    chk_ready = 1;
    start(16'h0700, 16'd8);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge h2c_clk); #1;
      end
      if (b == 1) begin
        h2c_addr = 16'hDEAD; h2c_len = 16'd0; h2c_en = 1'b1;
        @(posedge h2c_clk); #1;
        h2c_en = 1'b0;
      end
      send_beat({32'hB0000000 + 32'(2*b+1), 32'hB0000000 + 32'(2*b)}, 8'hFF, b == 3);
    end
    wait_idle();
    chk_ready = 0;
    tests++;
    if (wr_a.size() !== 8) begin
      fails++; $display("FAIL bp_count: got %0d writes, required 8", wr_a.size());
    end
    for (int i = 0; i < 8 && i < wr_a.size(); i++) begin
      tests++;
      if (wr_a[i] !== 16'h0700 + 16'(i) || wr_d[i] !== 32'hB0000000 + 32'(i)) begin
        fails++;
        $display("FAIL bp_write%0d: got %h<-%h, required %h<-%h", i, wr_a[i], wr_d[i],
                 16'h0700 + 16'(i), 32'hB0000000 + 32'(i));
      end
    end
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL bp_tready_in_wr_hi: got %0d cycles, required 0", viol);
    end
    tests++;
    if ({done_cnt, h2c_err_short, h2c_err_long} !== {32'd1, 2'b00}) begin
      fails++;
      $display("FAIL bp_status: done_cnt=%0d short=%b long=%b, required 1 0 0", done_cnt, h2c_err_short, h2c_err_long);
    end
  endtask

  task automatic test_reset_mid;
    clear_log();
    start(16'h0800, 16'd8);
    send_beat(64'h90000001_90000000, 8'hFF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({h2c.tready, sysRAM_we, h2c_busy, h2c_done, h2c_err_short, h2c_err_long, sysRAM_addr, sysRAM_wdata} !== 54'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: tready=%b we=%b busy=%b done=%b addr=%h wdata=%h, required all 0",
               h2c.tready, sysRAM_we, h2c_busy, h2c_done, sysRAM_addr, sysRAM_wdata);
    end
    @(posedge h2c_clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge h2c_clk); #1;
    end
    tests++;
    if (done_cnt !== 0) begin
      fails++; $display("FAIL reset_mid_no_done: done_cnt=%0d, required 0", done_cnt);
    end
    clear_log();
    start(16'h0900, 16'd2);
    send_beat(64'h80000001_80000000, 8'hFF, 1'b1);
    wait_idle();
    tests++;
    if (wr_a.size() !== 2) begin
      fails++; $display("FAIL reset_mid_restart_count: got %0d writes, required 2", wr_a.size());
    end else begin
      tests++;
      if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {16'h0900, 32'h80000000, 16'h0901, 32'h80000001}) begin
        fails++;
        $display("FAIL reset_mid_restart_writes: got %h<-%h %h<-%h, required 0900<-80000000 0901<-80000001",
                 wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++; $display("FAIL reset_mid_restart_done: done_cnt=%0d, required 1", done_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_odd();
    test_short();
    test_long();
    test_keep_wrap();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
